// File: rtl/reorder_scatter.sv
// Ping-pong frame buffer that emits each 2^AW-word frame in XOR-permuted order,
// tagging every word with its original in-frame offset.
module reorder_scatter #(
    parameter int              DW        = 32,
    parameter int              AW        = 10,
    parameter logic [AW-1:0]   SEED_INIT = '0,
    parameter logic [AW-1:0]   SEED_STEP = AW'(1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] src_dut_data,
    input  logic          src_dut_vld,
    output logic          dut_src_rdy,
    output logic [DW-1:0] dut_if1_data,
    output logic [AW-1:0] dut_if1_offset,
    output logic          dut_if1_vld,
    input  logic          if1_dut_rdy,
    output logic          frame_done
);
    localparam int N = 1 << AW;

    logic [DW-1:0] bank [2][N];
    logic          wr_sel, rd_sel;
    logic [AW-1:0] wr_cnt, rd_cnt, seed, rd_addr;
    logic [1:0]    bank_full;
    logic          in_acc, out_acc, wr_last, rd_last;

    assign dut_src_rdy = !bank_full[wr_sel];
    assign in_acc      = src_dut_vld && dut_src_rdy;
    assign dut_if1_vld = bank_full[rd_sel];
    assign out_acc     = dut_if1_vld && if1_dut_rdy;
    assign wr_last     = &wr_cnt;
    assign rd_last     = &rd_cnt;

    // XOR with a per-frame constant is a bijection, so each offset appears once per frame
    assign rd_addr        = rd_cnt ^ seed;
    assign dut_if1_offset = dut_if1_vld ? rd_addr : '0;
    assign dut_if1_data   = dut_if1_vld ? bank[rd_sel][rd_addr] : '0;

    always_ff @(posedge clk) begin
        if (in_acc) bank[wr_sel][wr_cnt] <= src_dut_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            bank_full  <= '0;
            seed       <= SEED_INIT;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (in_acc) begin
                wr_cnt <= wr_cnt + AW'(1);
                if (wr_last) wr_sel <= ~wr_sel;
            end
            if (out_acc) begin
                rd_cnt <= rd_cnt + AW'(1);
                if (rd_last) begin
                    rd_sel     <= ~rd_sel;
                    seed       <= seed + SEED_STEP;
                    frame_done <= 1'b1;
                end
            end
            // Writer and reader never own the same bank, so set and clear cannot collide
            for (int i = 0; i < 2; i++) begin
                if (in_acc && wr_last && wr_sel == 1'(i))  bank_full[i] <= 1'b1;
                if (out_acc && rd_last && rd_sel == 1'(i)) bank_full[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reorder_scatter.sv
// Randomized scoreboard bench for reorder_scatter: a frame-level model queues the
// expected (offset, data) sequence and a negedge monitor checks every output cycle.
module tb_reorder_scatter;
    localparam int DW = 32;
    localparam int AW = 2;
    localparam int N  = 1 << AW;
    localparam logic [AW-1:0] SI = 2'd0;
    localparam logic [AW-1:0] SS = 2'd1;

    typedef struct {
        logic [AW-1:0] off;
        logic [DW-1:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] src_dut_data;
    logic          src_dut_vld;
    logic          dut_src_rdy;
    logic [DW-1:0] dut_if1_data;
    logic [AW-1:0] dut_if1_offset;
    logic          dut_if1_vld;
    logic          if1_dut_rdy;
    logic          frame_done;

    reorder_scatter #(.DW(DW), .AW(AW), .SEED_INIT(SI), .SEED_STEP(SS)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_dut_data(src_dut_data), .src_dut_vld(src_dut_vld), .dut_src_rdy(dut_src_rdy),
        .dut_if1_data(dut_if1_data), .dut_if1_offset(dut_if1_offset),
        .dut_if1_vld(dut_if1_vld), .if1_dut_rdy(if1_dut_rdy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int            nvec = 0;
    int            nerr = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] cur_frame[$];
    int            fin = 0;
    bit            fd_exp = 1'b0;
    bit            mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " src_rdy"}, 64'(dut_src_rdy), 64'd1);
        chk({tag, " vld"}, 64'(dut_if1_vld), 64'd0);
        chk({tag, " offset"}, 64'(dut_if1_offset), 64'd0);
        chk({tag, " data"}, 64'(dut_if1_data), 64'd0);
        chk({tag, " frame_done"}, 64'(frame_done), 64'd0);
    endtask

    // One clock of stimulus; a completed input frame becomes its permuted expected sequence
    task automatic tick(input bit v, input logic [DW-1:0] d, input bit r);
        bit            acc;
        logic [AW-1:0] sd, o;
        src_dut_vld  = v;
        src_dut_data = d;
        if1_dut_rdy  = r;
        @(negedge clk);
        acc = v && dut_src_rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            cur_frame.push_back(d);
            if (cur_frame.size() == N) begin
                sd = AW'((int'(SI) + fin * int'(SS)) % N);
                for (int k = 0; k < N; k++) begin
                    o = AW'(k) ^ sd;
                    exp_q.push_back('{off: o, dat: cur_frame[o]});
                end
                cur_frame.delete();
                fin++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1'b0, '0, 1'b1);
        chk("drain empty", 64'(exp_q.size()), 64'd0);
        tick(1'b0, '0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("src_rdy", 64'(dut_src_rdy), 64'((exp_q.size() + N - 1) / N < 2));
            chk("vld", 64'(dut_if1_vld), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("offset", 64'(dut_if1_offset), 64'(exp_q[0].off));
                chk("data", 64'(dut_if1_data), 64'(exp_q[0].dat));
            end else begin
                chk("idle offset", 64'(dut_if1_offset), 64'd0);
                chk("idle data", 64'(dut_if1_data), 64'd0);
            end
            chk("frame_done", 64'(frame_done), 64'(fd_exp));
            fd_exp = 1'b0;
            if (dut_if1_vld && if1_dut_rdy && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                if (exp_q.size() % N == 0) fd_exp = 1'b1;
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        src_dut_vld  = 1'b0;
        src_dut_data = '0;
        if1_dut_rdy  = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("in reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk_idle_outputs("after reset");
        mon_en = 1'b1;

        // One full frame plus two words stalled, then reset mid-frame
        for (int i = 0; i < 6; i++) tick(1'b1, 32'h5000 + DW'(i), 1'b0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        cur_frame.delete();
        fin    = 0;
        fd_exp = 1'b0;
        #1 chk_idle_outputs("async reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Frames A, B, C back-to-back, downstream always ready
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N; i++) tick(1'b1, 32'hA0 + DW'(f * 16 + i), 1'b1);
        drain();

        // Backpressure: both banks fill, then one bank is released
        for (int i = 0; i < 12; i++) tick(1'b1, $urandom, 1'b0);
        chk("bp src_rdy low", 64'(dut_src_rdy), 64'd0);
        for (int i = 0; i < N; i++) tick(1'b0, '0, 1'b1);
        chk("bp src_rdy back", 64'(dut_src_rdy), 64'd1);
        drain();

        // Streaming: 16 frames at full rate
        for (int i = 0; i < 16 * N; i++) tick(1'b1, $urandom, 1'b1);
        drain();

        // Random handshakes for 1000 frames
        begin
            int target = fin + 1000;
            for (int c = 0; c < 40000 && fin < target; c++)
                tick($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
            chk("random frames", 64'(fin >= target), 64'd1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
